dma_ctrl: RTL and testbench

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/dma_ctrl_if.sv | 33 +++
 rtl/dma_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dma_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ctrl_if.sv
// Memory and PIM bus bundle for dma_ctrl.
// master = DMA engine side, slave = memory/PIM side.
interface dma_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int PIM_AW = 11
);
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wr_data_o;
  logic [XLEN-1:0]   mem_rd_data_i;
  logic [3:0]        mem_size_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [3:0]        pim_sel_o;
  logic [PIM_AW-1:0] pim_addr_o;
  logic [XLEN-1:0]   pim_wr_data_o;
  logic [XLEN-1:0]   pim_rd_data_i;
  logic              pim_read_o;
  logic              pim_write_o;

  modport master (
    output mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
    output pim_sel_o, pim_addr_o, pim_wr_data_o, pim_read_o, pim_write_o,
    input  mem_gnt_i, mem_rd_data_i, pim_rd_data_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
    input  pim_sel_o, pim_addr_o, pim_wr_data_o, pim_read_o, pim_write_o,
    output mem_gnt_i, mem_rd_data_i, pim_rd_data_i
  );
endinterface

// File: rtl/dma_ctrl.sv
// Word-granular DMA engine moving data between data memory and a PIM macro.
// Optional done pulse output is enabled by defining DMA_DONE_IRQ_EN.
//
// state  | meaning
// IDLE   | waiting for a valid command pulse
// MEM_RD | memory read request held until granted
// PIM_RD | one-cycle PIM read strobe
// XFER   | write the fetched word to the other side
// DONE   | one-cycle completion state, still busy
module dma_ctrl #(
  parameter int XLEN   = 32,
  parameter int PIM_AW = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dma_en_i,
  input  logic [2:0]        dma_funct3_i,
  input  logic [3:0]        dma_sel_pim_i,
  input  logic [12:0]       dma_size_i,
  input  logic [XLEN-1:0]   dma_mem_addr_i,
`ifdef DMA_DONE_IRQ_EN
  output logic              dma_done_o,
`endif
  output logic              dma_busy_o,
  dma_ctrl_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEM_RD = 3'd1,
    S_PIM_RD = 3'd2,
    S_XFER   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [PIM_AW-1:0] idx_q, idx_d;
  logic [10:0]       cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;

  logic              cmd_ok;
  logic              word_done;
  logic              mem_req, mem_rd, mem_wr;
  logic [XLEN-1:0]   mem_addr, mem_wdata;
  logic              pim_rd, pim_wr;
  logic [PIM_AW-1:0] pim_addr;
  logic [XLEN-1:0]   pim_wdata;
  logic              unused_bits;

  assign cmd_ok      = dma_en_i && (dma_funct3_i[2:1] == 2'b00) && (|dma_size_i[12:2]);
  assign unused_bits = ^{dma_size_i[1:0], dma_mem_addr_i[1:0]};

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    wdata_d   = wdata_q;
    hold_d    = 1'b0;
    word_done = 1'b0;
    mem_req   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pim_rd    = 1'b0;
    pim_wr    = 1'b0;
    pim_addr  = '0;
    pim_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_ok) begin
          sel_d   = dma_sel_pim_i;
          addr_d  = {dma_mem_addr_i[XLEN-1:2], 2'b00};
          cnt_d   = dma_size_i[12:2];
          idx_d   = '0;
          dir_d   = dma_funct3_i[0];
          state_d = dma_funct3_i[0] ? S_PIM_RD : S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        if (bus.mem_gnt_i) state_d = S_XFER;
      end
      S_PIM_RD: begin
        pim_rd   = 1'b1;
        pim_addr = idx_q;
        state_d  = S_XFER;
      end
      S_XFER: begin
        if (!dir_q) begin
          pim_wr    = 1'b1;
          pim_addr  = idx_q;
          pim_wdata = bus.mem_rd_data_i;
          word_done = 1'b1;
        end else begin
          // PIM read data is only valid on the first XFER cycle; hold a copy for grant stalls
          mem_req   = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = hold_q ? wdata_q : bus.pim_rd_data_i;
          wdata_d   = mem_wdata;
          hold_d    = !bus.mem_gnt_i;
          word_done = bus.mem_gnt_i;
        end
        if (word_done) begin
          addr_d  = addr_q + XLEN'(4);
          idx_d   = idx_q + PIM_AW'(1);
          cnt_d   = cnt_q - 11'd1;
          state_d = (cnt_q == 11'd1) ? S_DONE : (dir_q ? S_PIM_RD : S_MEM_RD);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign dma_busy_o        = busy_q;
  assign bus.mem_req_o     = mem_req;
  assign bus.mem_read_o    = mem_rd;
  assign bus.mem_write_o   = mem_wr;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_wr_data_o = mem_wdata;
  assign bus.mem_size_o    = mem_req ? 4'b1111 : 4'b0000;
  assign bus.pim_sel_o     = sel_q;
  assign bus.pim_addr_o    = pim_addr;
  assign bus.pim_wr_data_o = pim_wdata;
  assign bus.pim_read_o    = pim_rd;
  assign bus.pim_write_o   = pim_wr;

`ifdef DMA_DONE_IRQ_EN
  assign dma_done_o = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: a transaction-list model predicts every bus access,
// a negedge monitor compares each cycle, and literal values pin the model.
module tb_dma_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_en = 1'b0;
  logic [2:0]  f3 = '0;
  logic [3:0]  sel = '0;
  logic [12:0] size = '0;
  logic [31:0] maddr = '0;
  logic        busy;
`ifdef DMA_DONE_IRQ_EN
  logic        done;
  int          done_cnt = 0;
`endif

  dma_ctrl_if #(.XLEN(32), .PIM_AW(11)) bus ();

  dma_ctrl #(.XLEN(32), .PIM_AW(11)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dma_en_i       (dma_en),
    .dma_funct3_i   (f3),
    .dma_sel_pim_i  (sel),
    .dma_size_i     (size),
    .dma_mem_addr_i (maddr),
`ifdef DMA_DONE_IRQ_EN
    .dma_done_o     (done),
`endif
    .dma_busy_o     (busy),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } xact_t;

  logic [31:0] q_rd[$];
  logic [31:0] q_pr[$];
  xact_t       q_pw[$];
  xact_t       q_mw[$];
  logic [31:0] rd_log[$];
  xact_t       pw_log[$];
  xact_t       mw_log[$];

  int          nerr = 0;
  int          nchk = 0;
  int          acc_cnt = 0;
  int          stall_word = -1;
  int          stall_left = 0;
  logic [3:0]  cur_sel = '0;
  bit          rd_pend = 1'b0;
  bit          pr_pend = 1'b0;
  logic [31:0] rd_a = '0;
  logic [31:0] pr_i = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] pimf(input logic [31:0] i);
    return 32'hC0DE_0000 | i;
  endfunction

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory / PIM responder: read data appears one cycle after the accepted request
  always @(posedge clk) begin
    #1;
    bus.mem_rd_data_i = rd_pend ? memf(rd_a) : 32'hDEAD_BEEF;
    bus.pim_rd_data_i = pr_pend ? pimf(pr_i) : 32'hBAAD_F00D;
  end

  always @(negedge clk) begin
    if (bus.mem_req_o && acc_cnt == stall_word && stall_left > 0) begin
      bus.mem_gnt_i = 1'b0;
      stall_left--;
    end else begin
      bus.mem_gnt_i = 1'b1;
    end
    rd_pend = 1'b0;
    pr_pend = 1'b0;
    if (rst_n) begin
      if (busy) chk_eq("pim_sel", 32'(bus.pim_sel_o), 32'(cur_sel));
`ifdef DMA_DONE_IRQ_EN
      if (done) done_cnt++;
`endif
      if (bus.mem_req_o) begin
        chk_eq("mem_size", 32'(bus.mem_size_o), 32'hF);
        chk_eq("mem rd/wr exclusive", 32'(bus.mem_read_o ^ bus.mem_write_o), 32'd1);
        if (bus.mem_read_o) begin
          chk_eq("unexpected mem read", 32'(q_rd.size() != 0), 32'd1);
          if (q_rd.size() != 0) begin
            chk_eq("mem read addr", bus.mem_addr_o, q_rd[0]);
            if (bus.mem_gnt_i) begin
              rd_log.push_back(bus.mem_addr_o);
              rd_pend = 1'b1;
              rd_a    = bus.mem_addr_o;
              void'(q_rd.pop_front());
              acc_cnt++;
            end
          end
        end
        if (bus.mem_write_o) begin
          chk_eq("unexpected mem write", 32'(q_mw.size() != 0), 32'd1);
          if (q_mw.size() != 0) begin
            chk_eq("mem write addr", bus.mem_addr_o, q_mw[0].a);
            chk_eq("mem write data", bus.mem_wr_data_o, q_mw[0].d);
            if (bus.mem_gnt_i) begin
              mw_log.push_back('{a: bus.mem_addr_o, d: bus.mem_wr_data_o});
              void'(q_mw.pop_front());
              acc_cnt++;
            end
          end
        end
      end
      if (bus.pim_write_o) begin
        chk_eq("unexpected pim write", 32'(q_pw.size() != 0), 32'd1);
        if (q_pw.size() != 0) begin
          chk_eq("pim write addr", 32'(bus.pim_addr_o), q_pw[0].a);
          chk_eq("pim write data", bus.pim_wr_data_o, q_pw[0].d);
          pw_log.push_back('{a: 32'(bus.pim_addr_o), d: bus.pim_wr_data_o});
          void'(q_pw.pop_front());
        end
      end
      if (bus.pim_read_o) begin
        chk_eq("unexpected pim read", 32'(q_pr.size() != 0), 32'd1);
        if (q_pr.size() != 0) begin
          chk_eq("pim read addr", 32'(bus.pim_addr_o), q_pr[0]);
          pr_pend = 1'b1;
          pr_i    = 32'(bus.pim_addr_o);
          void'(q_pr.pop_front());
        end
      end
      if (!busy)
        chk_eq("strobes while idle",
               32'({bus.mem_req_o, bus.mem_read_o, bus.mem_write_o, bus.pim_read_o, bus.pim_write_o}),
               32'd0);
    end
  end

  // Model: a valid command expands into its full list of expected bus transactions
  task automatic issue(input logic [2:0] c_f3, input logic [12:0] c_size,
                       input logic [31:0] c_addr, input logic [3:0] c_sel);
    int          n;
    logic [31:0] base;
    @(negedge clk);
    f3     = c_f3;
    size   = c_size;
    maddr  = c_addr;
    sel    = c_sel;
    dma_en = 1'b1;
    rd_log.delete();
    pw_log.delete();
    mw_log.delete();
`ifdef DMA_DONE_IRQ_EN
    done_cnt = 0;
`endif
    n    = int'(c_size) / 4;
    base = c_addr & 32'hFFFF_FFFC;
    if ((c_f3 == 3'b000 || c_f3 == 3'b001) && n != 0) begin
      cur_sel = c_sel;
      acc_cnt = 0;
      for (int i = 0; i < n; i++) begin
        if (c_f3 == 3'b000) begin
          q_rd.push_back(base + 32'(4 * i));
          q_pw.push_back('{a: 32'(i), d: memf(base + 32'(4 * i))});
        end else begin
          q_pr.push_back(32'(i));
          q_mw.push_back('{a: base + 32'(4 * i), d: pimf(32'(i))});
        end
      end
    end
    @(negedge clk);
    dma_en = 1'b0;
  endtask

  task automatic wait_busy(output int n, input bit inject);
    n = 0;
    while (busy === 1'b1 && n < 6000) begin
      n++;
      if (inject && n == 1) begin
        f3 = 3'b001; size = 13'd16; maddr = 32'h40; sel = 4'b1111; dma_en = 1'b1;
      end
      if (inject && n == 2) dma_en = 1'b0;
      @(negedge clk);
    end
    dma_en = 1'b0;
    if (n >= 6000) chk_eq("busy timeout", 32'(n), 32'd0);
  endtask

  task automatic run(input logic [2:0] c_f3, input logic [12:0] c_size, input logic [31:0] c_addr,
                     input logic [3:0] c_sel, input int exp_busy, input bit inject);
    int n;
    issue(c_f3, c_size, c_addr, c_sel);
    wait_busy(n, inject);
    chk_eq("busy cycles", 32'(n), 32'(exp_busy));
    repeat (3) @(negedge clk);
    chk_eq("busy after end", 32'(busy), 32'd0);
    chk_eq("leftover expectations", 32'(q_rd.size() + q_pr.size() + q_pw.size() + q_mw.size()), 32'd0);
`ifdef DMA_DONE_IRQ_EN
    chk_eq("done pulses", 32'(done_cnt), 32'(exp_busy > 0));
`endif
  endtask

  initial begin
    logic [31:0] lit_pw[4];
    lit_pw = '{32'h5A5A_0100, 32'h5A5A_0104, 32'h5A5A_0108, 32'h5A5A_010C};

    repeat (3) @(negedge clk);
    chk_eq("reset busy", 32'(busy), 32'd0);
    chk_eq("reset strobes",
           32'({bus.mem_req_o, bus.mem_read_o, bus.mem_write_o, bus.pim_read_o, bus.pim_write_o}), 32'd0);
    chk_eq("reset pim_sel", 32'(bus.pim_sel_o), 32'd0);
    rst_n = 1'b1;

    // MEM->PIM, 4 words, grant always
    run(3'b000, 13'd16, 32'h0000_0100, 4'b0001, 9, 1'b0);
    chk_eq("m2p write count", 32'(pw_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < pw_log.size()) begin
        chk_eq("m2p literal addr", pw_log[i].a, 32'(i));
        chk_eq("m2p literal data", pw_log[i].d, lit_pw[i]);
      end
    end

    // PIM->MEM, misaligned base
    run(3'b001, 13'd8, 32'h0000_0202, 4'b0010, 5, 1'b0);
    chk_eq("p2m write count", 32'(mw_log.size()), 32'd2);
    if (mw_log.size() == 2) begin
      chk_eq("p2m literal addr0", mw_log[0].a, 32'h0000_0200);
      chk_eq("p2m literal data0", mw_log[0].d, 32'hC0DE_0000);
      chk_eq("p2m literal addr1", mw_log[1].a, 32'h0000_0204);
      chk_eq("p2m literal data1", mw_log[1].d, 32'hC0DE_0001);
    end

    // MEM->PIM with grant withheld 3 cycles on word 1
    stall_word = 1; stall_left = 3;
    run(3'b000, 13'd16, 32'h0000_0300, 4'b0100, 12, 1'b0);
    chk_eq("stall pim writes", 32'(pw_log.size()), 32'd4);

    // PIM->MEM with write grant withheld 2 cycles on word 1
    stall_word = 1; stall_left = 2;
    run(3'b001, 13'd12, 32'h0000_0500, 4'b0001, 9, 1'b0);
    stall_word = -1;
    chk_eq("stall mem writes", 32'(mw_log.size()), 32'd3);

    // Ignored commands
    run(3'b011, 13'd16, 32'h0000_0100, 4'b0001, 0, 1'b0);
    run(3'b000, 13'd3,  32'h0000_0100, 4'b0001, 0, 1'b0);
    run(3'b001, 13'd0,  32'h0000_0100, 4'b0001, 0, 1'b0);

    // Address wrap
    run(3'b000, 13'd8, 32'hFFFF_FFFC, 4'b1000, 5, 1'b0);
    chk_eq("wrap read count", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      chk_eq("wrap first addr", rd_log[0], 32'hFFFF_FFFC);
      chk_eq("wrap second addr", rd_log[1], 32'h0000_0000);
    end

    // Command pulse while busy is ignored
    run(3'b000, 13'd8, 32'h0000_0600, 4'b0010, 5, 1'b1);

    // Largest transfer: PIM index runs 0..2046
    run(3'b000, 13'h1FFF, 32'h0000_1000, 4'b1000, 4095, 1'b0);
    chk_eq("long write count", 32'(pw_log.size()), 32'd2047);
    if (pw_log.size() == 2047) chk_eq("long last index", pw_log[2046].a, 32'd2046);

    // Reset during word 2 of 4, then a fresh command
    issue(3'b000, 13'd16, 32'h0000_0400, 4'b0001);
    for (int k = 0; k < 20 && pw_log.size() < 1; k++) @(negedge clk);
    chk_eq("reached word 2", 32'(pw_log.size() >= 1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("async rst busy", 32'(busy), 32'd0);
    chk_eq("async rst strobes",
           32'({bus.mem_req_o, bus.mem_read_o, bus.mem_write_o, bus.pim_read_o, bus.pim_write_o,
                bus.mem_size_o, bus.pim_sel_o}), 32'd0);
    chk_eq("async rst mem_addr", bus.mem_addr_o, 32'd0);
    chk_eq("async rst pim_addr", 32'(bus.pim_addr_o), 32'd0);
    chk_eq("async rst wr data", bus.mem_wr_data_o | bus.pim_wr_data_o, 32'd0);
    q_rd.delete(); q_pr.delete(); q_pw.delete(); q_mw.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(3'b001, 13'd12, 32'h0000_0800, 4'b0010, 7, 1'b0);
    chk_eq("post-reset writes", 32'(mw_log.size()), 32'd3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
